// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and defaults for the register file dump reader.
// REGDUMP_CHECKSUM_EN adds the trailing XOR-checksum word to the stream.
package regfile_dump_reader_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd3,
        ST_SUM  = 3'd4
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying one register word per beat to the debug side.
// REGDUMP_CHECKSUM_EN adds out_is_sum to flag the checksum beat.
interface regfile_dump_reader_if
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef REGDUMP_CHECKSUM_EN
    logic              out_is_sum;

    modport master (output out_valid, out_index, out_data, out_last, out_is_sum, input out_ready);
    modport slave  (input out_valid, out_index, out_data, out_last, out_is_sum, output out_ready);
`else
    modport master (output out_valid, out_index, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_index, out_data, out_last, output out_ready);
`endif
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive (wrapping) register range and streams each value while holding the core.
// Optional trailing XOR checksum word is built when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic              busy,
    output logic              done,
    output logic              rf_hold,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    regfile_dump_reader_if.master out_if
);

    dump_state_t       state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] end_r;
    logic              busy_r;
    logic              done_r;
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_index_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_r;
    logic              at_end_r;
    logic              out_is_sum_r;
`endif

    // The read pointer doubles as the read-port index so it is stable through READ and SEND.
    assign rf_read_reg      = ptr_r;
    assign busy             = busy_r;
    assign rf_hold          = busy_r;
    assign done             = done_r;
    assign out_if.out_valid = out_valid_r;
    assign out_if.out_index = out_index_r;
    assign out_if.out_data  = out_data_r;
    assign out_if.out_last  = out_last_r;
`ifdef REGDUMP_CHECKSUM_EN
    assign out_if.out_is_sum = out_is_sum_r;
`endif

    // Dump sequencer: all control and stream outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {ADDR_W{1'b0}};
            end_r       <= {ADDR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_index_r <= {ADDR_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_r        <= {DATA_W{1'b0}};
            at_end_r     <= 1'b0;
            out_is_sum_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        ptr_r   <= first_reg;
                        end_r   <= last_reg;
                        busy_r  <= 1'b1;
                        state_r <= ST_READ;
`ifdef REGDUMP_CHECKSUM_EN
                        acc_r        <= {DATA_W{1'b0}};
                        out_is_sum_r <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    out_data_r  <= rf_read_data;
                    out_index_r <= ptr_r;
                    out_valid_r <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    // In this build out_last belongs to the checksum beat only.
                    at_end_r   <= (ptr_r == end_r);
                    out_last_r <= 1'b0;
`else
                    out_last_r <= (ptr_r == end_r);
`endif
                    state_r <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_valid_r && out_if.out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                        if (at_end_r) begin
                            out_data_r   <= acc_r ^ out_data_r;
                            out_index_r  <= {ADDR_W{1'b0}};
                            out_is_sum_r <= 1'b1;
                            out_last_r   <= 1'b1;
                            out_valid_r  <= 1'b1;
                            state_r      <= ST_SUM;
                        end else begin
                            acc_r       <= acc_r ^ out_data_r;
                            ptr_r       <= ptr_r + ADDR_W'(1);
                            out_valid_r <= 1'b0;
                            state_r     <= ST_READ;
                        end
`else
                        out_valid_r <= 1'b0;
                        if (out_last_r) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            ptr_r   <= ptr_r + ADDR_W'(1);
                            state_r <= ST_READ;
                        end
`endif
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                ST_SUM: begin
                    if (out_valid_r && out_if.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_SUM;
                    end
                end
`endif
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a model register file feeds the read port,
// expected words are queued at start and compared beat by beat (checksum beat under REGDUMP_CHECKSUM_EN).
module tb_regfile_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        busy;
    logic        done;
    logic        rf_hold;
    logic [4:0]  rf_read_reg;
    logic [31:0] rf_read_data;
    logic [31:0] rf [32];

    regfile_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) dump_if ();

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .busy         (busy),
        .done         (done),
        .rf_hold      (rf_hold),
        .rf_read_reg  (rf_read_reg),
        .rf_read_data (rf_read_data),
        .out_if       (dump_if.master)
    );

    assign rf_read_data = rf[rf_read_reg];

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        is_sum;
    } word_t;

    word_t sb[$];
    int    checks      = 0;
    int    failures    = 0;
    int    cyc         = 0;
    int    done_exp_cyc = -1;
    bit    done_flag   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time the done pulse.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Model of the walk: wrapping range, optional XOR checksum beat.
    task automatic push_dump(input logic [4:0] f, input logic [4:0] l);
        logic [4:0]  idx;
        logic [4:0]  span;
        logic [31:0] acc;
        word_t       w;
        span = l - f;
        idx  = f;
        acc  = 32'h0;
        for (int i = 0; i <= int'(span); i++) begin
            w.idx    = idx;
            w.data   = rf[idx];
            w.is_sum = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            w.last   = 1'b0;
`else
            w.last   = (i == int'(span));
`endif
            acc = acc ^ rf[idx];
            sb.push_back(w);
            idx = idx + 5'd1;
        end
`ifdef REGDUMP_CHECKSUM_EN
        w.idx = 5'd0; w.data = acc; w.last = 1'b1; w.is_sum = 1'b1;
        sb.push_back(w);
`endif
    endtask

    // Stream monitor: compares every presented beat (including stalled ones) with the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (done_exp_cyc == cyc) begin
                check_eq("done_pulse", done, 1'b1);
                check_eq("busy_low_in_done", {busy, rf_hold}, 2'b00);
                done_exp_cyc = -1;
                done_flag    = 1'b1;
            end else if (done) begin
                check_eq("done_spurious", done, 1'b0);
            end
            if (dump_if.out_valid) begin
                check_eq("hold_while_valid", {busy, rf_hold}, 2'b11);
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    check_eq("out_index", dump_if.out_index, sb[0].idx);
                    check_eq("out_data", dump_if.out_data, sb[0].data);
                    check_eq("out_last", dump_if.out_last, sb[0].last);
`ifdef REGDUMP_CHECKSUM_EN
                    check_eq("out_is_sum", dump_if.out_is_sum, sb[0].is_sum);
`endif
                    if (dump_if.out_ready) begin
                        if (sb[0].last) done_exp_cyc = cyc + 1;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        @(posedge clk); #1;
        start = 1'b1; first_reg = f; last_reg = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!dump_if.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, dump_if.out_valid, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_flag && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, done_flag, 1'b1);
        check_eq({tag, "_sb_empty"}, sb.size(), 0);
        done_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; first_reg = 5'd0; last_reg = 5'd0;
        dump_if.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i) * 32'h0000_0101;
        rf[3] = 32'h11; rf[4] = 32'h22; rf[5] = 32'h33;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_ctrl", {busy, done, rf_hold, dump_if.out_valid, dump_if.out_last}, 5'b0);
        check_eq("rst_data", {dump_if.out_index, dump_if.out_data, rf_read_reg}, 42'h0);

        // 3..5 at full rate, with start-to-valid latency
        push_dump(5'd3, 5'd5);
        do_start(5'd3, 5'd5);
        @(negedge clk);
        check_eq("lat1_busy", {busy, rf_hold}, 2'b11);
        check_eq("lat1_valid", dump_if.out_valid, 1'b0);
        @(negedge clk);
        check_eq("lat2_valid", dump_if.out_valid, 1'b1);
        wait_done("dump_3_5");

        // wrapping range 30..1
        push_dump(5'd30, 5'd1);
        do_start(5'd30, 5'd1);
        wait_done("dump_wrap");

        // single word with backpressure
        dump_if.out_ready = 1'b0;
        push_dump(5'd7, 5'd7);
        do_start(5'd7, 5'd7);
        wait_valid("single_valid");
        repeat (5) begin @(posedge clk); #1; end
        dump_if.out_ready = 1'b1;
        wait_done("dump_single");

        // reset during SEND of the 2nd word
        dump_if.out_ready = 1'b0;
        push_dump(5'd3, 5'd5);
        do_start(5'd3, 5'd5);
        wait_valid("abort_w1_valid");
        dump_if.out_ready = 1'b1;
        @(posedge clk); #1;
        dump_if.out_ready = 1'b0;
        wait_valid("abort_w2_valid");
        check_eq("abort_w2_index", dump_if.out_index, 5'd4);
        reset = 1'b1;
        sb.delete();
        done_exp_cyc = -1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_state", {dump_if.out_valid, busy, rf_hold, done}, 4'b0);
        dump_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_flag, 1'b0);

        // start pulsed while busy is ignored
        push_dump(5'd3, 5'd5);
        do_start(5'd3, 5'd5);
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd0;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_done("dump_ignore_start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/trace-side reader for the 32x32 register file.
- On request, walks an inclusive register index range and emits each register value over a valid/ready stream.
- Asserts a hold to the core so that no write or swap lands mid-dump, giving a consistent snapshot.
- Sits between the register file's read port (shared via mux, owned by this block while busy) and the debug/trace interface.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width (32 registers).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- first_reg  input  ADDR_W  first index of range, latched on accepted start
- last_reg  input  ADDR_W  last index of range (inclusive), latched on accepted start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after last word handshakes
- rf_hold  output  1  equals busy; core must suppress RegWrite/Swap and steer read port 1 to rf_read_reg
- rf_read_reg  output  ADDR_W  register index driven to register file read port
- rf_read_data  input  DATA_W  combinational read data for rf_read_reg
- out_valid  output  1  stream word valid
- out_ready  input  1  consumer ready
- out_index  output  ADDR_W  register index of current word
- out_data  output  DATA_W  register value
- out_last  output  1  marks final word of dump

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - busy, done, rf_hold, out_valid and out_last are 0.
  - out_index, out_data and rf_read_reg are 0.
  - Takes effect mid-dump; the partial stream is abandoned with no done pulse.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - On start=1: latch ptr<=first_reg, end<=last_reg, go to READ; busy/rf_hold rise the next cycle.
  - start is ignored in every other state.
- READ:
  - rf_read_reg=ptr.
  - At clock edge: out_data<=rf_read_data, out_index<=ptr, out_last<=(ptr==end). Go to SEND.
- SEND:
  - out_valid=1; out_data, out_index and out_last hold stable until out_valid&&out_ready.
  - On handshake with out_last=1: go to DONE.
  - On handshake otherwise: ptr<=ptr+1 (mod 2^ADDR_W), go to READ.
- DONE:
  - done=1 for exactly one cycle; busy/rf_hold deassert in the same cycle; next state IDLE.
- Range wrap:
  - If last_reg<first_reg, the walk wraps 31->0.
  - Word count = ((last_reg-first_reg) mod 32)+1.
  - first_reg==last_reg gives exactly one word.
- Throughput and latency:
  - One word per 2 cycles with out_ready held high.
  - First out_valid appears 2 cycles after the start cycle.
- Backpressure: out_ready low for any duration stalls in SEND with outputs stable.
- rf_read_reg: holds ptr value in SEND as well, so the read port is stable.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- When defined:
  - Adds state SUM and output out_is_sum (1 bit).
  - An accumulator XORs every emitted out_data; it is cleared on accepted start.
  - After the handshake of the last register word, enters SUM and presents out_data=accumulator, out_index=0, out_is_sum=1, out_valid=1.
  - In this build out_last marks the SUM word, not the last register word.
  - SUM goes to DONE on handshake.
- When undefined:
  - No accumulator, no SUM state, no out_is_sum port.
  - out_last marks the last register word.

Decomposition:
- Shared package: state encoding constants (IDLE/READ/SEND/DONE/SUM), REG_COUNT=32, DATA_W/ADDR_W defaults.
- No sub-module required.
- The checksum accumulator stays inline under the macro; a separate module adds no value.

Test Plan:
- Preload r3=0x11, r4=0x22, r5=0x33; start with first=3, last=5, out_ready=1 -> 3 words (3,0x11),(4,0x22),(5,0x33), out_last only on index 5, done pulses 1 cycle after the third handshake, rf_hold high throughout.
- first=30, last=1, distinct values per register -> indices 30,31,0,1 in order; 4 words total.
- first=last=7, out_ready low for 5 cycles after out_valid rises -> out_valid/out_data/out_index stable for all 5 cycles; single word with out_last=1; done after the handshake.
- Assert reset while in SEND of the 2nd word of a 3-5 dump -> next cycle out_valid=0, busy=0, rf_hold=0, no done; a new start is accepted normally.
- Pulse start while busy with first=0 -> ignored; the original range completes unchanged.
- With REGDUMP_CHECKSUM_EN defined, r3=0x11, r4=0x22, r5=0x33, dump 3-5 -> 4th word out_data=0x00, out_is_sum=1, out_last=1; the last register word has out_last=0.
